dm_sized_mem: RTL

//  Parametrised byte-addressable data memory for the CPU datapath, little-endian.

---
 rtl/dm_pkg.sv | 23 ++
 rtl/dm_load_ext.sv | 25 ++
 rtl/dm_sized_mem.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - size/error encodings and FSM state type for the sized data memory
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int ERR_MIS = 0;
  localparam int ERR_OOR = 1;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} dm_state_t;

  // Size 2'b11 has no legal alignment, so it always reports misaligned.
  function automatic logic dm_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - selects the addressed byte/half/word lane and sign/zero-extends it
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;

  assign w_shifted = i_word >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B:    o_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/dm_sized_mem.sv
// rtl/dm_sized_mem.sv - little-endian byte-addressable data memory with clear-on-reset FSM
module dm_sized_mem
  import dm_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [31:0]       data_o,
  output logic [1:0]        err_o
);

  localparam int IDX_W     = $clog2(DEPTH_BYTES);
  localparam int CLR_WORDS = DEPTH_BYTES / 4;
  localparam int WIDX_W    = IDX_W - 2;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(CLR_WORDS - 1);

  dm_state_t         r_state, w_state_nxt;
  logic [WIDX_W-1:0] r_clr_idx, w_clr_idx_nxt;
  logic              w_clr_we, w_ready;
  logic [31:0]       r_mem [CLR_WORDS];

  logic              w_acc, w_st_we, w_respond;
  logic [1:0]        w_err, w_lo;
  logic [WIDX_W-1:0] w_widx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_word, w_ld_data;

  logic              r_valid;
  logic [31:0]       r_data;
  logic [1:0]        r_err;

  assign w_lo           = addr_i[1:0];
  assign w_widx         = addr_i[IDX_W-1:2];
  assign w_err[ERR_MIS] = dm_misaligned(size_i, w_lo);
  assign w_err[ERR_OOR] = |addr_i[ADDR_W-1:IDX_W];
  assign w_acc          = req_i && w_ready;
  assign w_st_we        = w_acc && we_i && (w_err == 2'b00);
  assign w_respond      = w_acc && (!we_i || (w_err != 2'b00));
  assign w_wdata        = data_i << {w_lo, 3'b000};

  always_comb begin
    case (size_i)
      SZ_B:    w_be = 4'b0001 << w_lo;
      SZ_H:    w_be = 4'b0011 << w_lo;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    w_ready       = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == LAST_WORD) w_state_nxt = RUN;
      end
      RUN:     w_ready = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // The array itself is not reset; the CLEAR pass zeroes it before any request is accepted.
  always_ff @(posedge clk_i) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_st_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  assign w_word = r_mem[w_widx];

  dm_load_ext u_load_ext (
    .i_size     (size_i),
    .i_unsigned (unsigned_i),
    .i_addr_lo  (w_lo),
    .i_word     (w_word),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= '0;
    end else begin
      r_valid <= w_respond;
      if (w_respond) begin
        r_err  <= w_err;
        r_data <= (w_err == 2'b00) ? w_ld_data : 32'h0;
      end
    end
  end

  assign ready_o = w_ready;
  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign err_o   = r_err;

endmodule
